// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the sync_fifo_pf buffer family.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 8;

  // Width needed to hold an occupancy of 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_pf_if.sv
// Bus bundle for sync_fifo_pf: the write/read request side (master) and the FIFO side (slave).
interface sync_fifo_pf_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) ();

  localparam int CNT_W = cnt_width(FIFO_DEPTH);

  // A request is taken on the rising edge where wr_en (rd_en) is high, the FIFO
  // can accept it (!full for writes, !empty for reads) and flush is low;
  // wr_ack/overflow/underflow report that decision during the following cycle.
  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  almostfull;
  logic                  empty;
  logic                  almostempty;
  logic [CNT_W-1:0]      count;

  modport master (
    output flush, wr_en, data_in, rd_en,
    input  data_out, wr_ack, overflow, underflow,
    input  full, almostfull, empty, almostempty, count
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en,
    output data_out, wr_ack, overflow, underflow,
    output full, almostfull, empty, almostempty, count
  );

endinterface

// File: rtl/fifo_mem.sv
// Register-array storage: synchronous write port, asynchronous read port, no reset.
module fifo_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_pf.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds,
// optional first-word-fall-through read data and a synchronous flush.
module sync_fifo_pf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int AF_THRESH  = FIFO_DEPTH - 1,
  parameter int AE_THRESH  = 1,
  parameter bit FWFT       = 1'b0
) (
  input logic            clk,
  input logic            rst_n,
  sync_fifo_pf_if.slave  bus
);

  localparam int CNT_W = cnt_width(FIFO_DEPTH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(FIFO_DEPTH - 1);

  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_pf: FIFO_DEPTH must be at least 2");
  end
  if (AE_THRESH < 1 || AE_THRESH >= AF_THRESH || AF_THRESH > FIFO_DEPTH - 1) begin : g_bad_thresh
    $error("sync_fifo_pf: thresholds need 1 <= AE_THRESH < AF_THRESH <= FIFO_DEPTH-1");
  end

  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;
  logic                  wr_ack_q, overflow_q, underflow_q;
  logic [DATA_WIDTH-1:0] head;

  assign full   = (count == DEPTH_C);
  assign empty  = (count == '0);
  assign wr_acc = bus.wr_en && !full && !bus.flush;
  assign rd_acc = bus.rd_en && !empty && !bus.flush;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (bus.data_in),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ack_q    <= wr_acc;
      overflow_q  <= bus.wr_en && full && !bus.flush;
      underflow_q <= bus.rd_en && empty && !bus.flush;
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_acc) wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
        if (rd_acc) rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
        case ({wr_acc, rd_acc})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  if (FWFT) begin : g_fwft
    assign bus.data_out = empty ? '0 : head;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] data_q;
    // Holds across flush; only an accepted read or reset changes it.
    always_ff @(posedge clk) begin
      if (!rst_n)      data_q <= '0;
      else if (rd_acc) data_q <= head;
    end
    assign bus.data_out = data_q;
  end

  assign bus.count       = count;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almostfull  = (count >= AF_C) && !full;
  assign bus.almostempty = (count <= AE_C) && !empty;
  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_sync_fifo_pf.sv
// Bench for sync_fifo_pf: one registered-read and one FWFT instance share stimulus
// and are checked each cycle against a queue-based model of the FIFO contract.
module tb_sync_fifo_pf;
  import fifo_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;
  localparam int CW    = cnt_width(DEPTH);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_pf_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus0 ();
  sync_fifo_pf_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus1 ();

  sync_fifo_pf #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  sync_fifo_pf #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [DW-1:0] dout0;
    logic [DW-1:0] dout1;
    logic [CW-1:0] count;
    logic full, afull, empty, aempty, ack, ovf, unf;
  } exp_t;

  localparam int EW = $bits(exp_t);
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] model_dout0 = '0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic rst, input logic w, input logic r, input logic f,
                       input logic [DW-1:0] d);
    exp_t e;
    int   sz, n;
    logic wa, ra;
    @(negedge clk);
    rst_n = !rst;
    bus0.flush = f; bus0.wr_en = w; bus0.rd_en = r; bus0.data_in = d;
    bus1.flush = f; bus1.wr_en = w; bus1.rd_en = r; bus1.data_in = d;
    e = '0;
    if (rst) begin
      model_q.delete();
      model_dout0 = '0;
    end else begin
      sz = model_q.size();
      wa = w && (sz < DEPTH) && !f;
      ra = r && (sz > 0) && !f;
      e.ack = wa;
      e.ovf = w && (sz == DEPTH) && !f;
      e.unf = r && (sz == 0) && !f;
      if (f) model_q.delete();
      else begin
        if (ra) model_dout0 = model_q.pop_front();
        if (wa) model_q.push_back(d);
      end
    end
    n        = model_q.size();
    e.count  = CW'(n);
    e.full   = (n == DEPTH);
    e.empty  = (n == 0);
    e.afull  = (n >= AF) && (n != DEPTH);
    e.aempty = (n <= AE) && (n != 0);
    e.dout1  = (n != 0) ? model_q[0] : '0;
    e.dout0  = model_dout0;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic wr(input logic [DW-1:0] d); cycle(1'b0, 1'b1, 1'b0, 1'b0, d); endtask
  task automatic rd();                       cycle(1'b0, 1'b0, 1'b1, 1'b0, '0); endtask
  task automatic idle();                     cycle(1'b0, 1'b0, 1'b0, 1'b0, '0); endtask
  task automatic rst();                      cycle(1'b1, 1'b0, 1'b0, 1'b0, '0); endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count0",     32'(bus0.count),       32'(e.count));
        chk("count1",     32'(bus1.count),       32'(e.count));
        chk("full0",      32'(bus0.full),        32'(e.full));
        chk("full1",      32'(bus1.full),        32'(e.full));
        chk("empty0",     32'(bus0.empty),       32'(e.empty));
        chk("empty1",     32'(bus1.empty),       32'(e.empty));
        chk("afull0",     32'(bus0.almostfull),  32'(e.afull));
        chk("aempty0",    32'(bus0.almostempty), 32'(e.aempty));
        chk("aempty1",    32'(bus1.almostempty), 32'(e.aempty));
        chk("wr_ack0",    32'(bus0.wr_ack),      32'(e.ack));
        chk("wr_ack1",    32'(bus1.wr_ack),      32'(e.ack));
        chk("overflow0",  32'(bus0.overflow),    32'(e.ovf));
        chk("overflow1",  32'(bus1.overflow),    32'(e.ovf));
        chk("underflow0", 32'(bus0.underflow),   32'(e.unf));
        chk("underflow1", 32'(bus1.underflow),   32'(e.unf));
        chk("data_out0",  32'(bus0.data_out),    32'(e.dout0));
        chk("data_out1",  32'(bus1.data_out),    32'(e.dout1));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus0.flush = 1'b0; bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.data_in = '0;
    bus1.flush = 1'b0; bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.data_in = '0;

    rst(); rst();
    // fill 1..8, then a rejected write
    for (int i = 1; i <= DEPTH; i++) wr(DW'(i));
    wr(16'h0009);
    // drain in order, then a rejected read
    for (int i = 0; i < DEPTH; i++) rd();
    rd();
    idle();
    // steady count 4 with concurrent read/write across pointer wrap
    for (int i = 0; i < 4; i++) wr(DW'($urandom_range(0, 16'hffff)));
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, DW'($urandom_range(0, 16'hffff)));
    // from full, write+read together
    for (int i = 0; i < 4; i++) wr(DW'(16'h0100 + i));
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'hdead);
    // down to 5, then flush together with a write
    rd(); rd();
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h5555);
    idle();
    rd();
    // FWFT single word, then a reset in the middle of a burst
    rst();
    wr(16'habcd);
    idle();
    rd();
    idle();
    for (int i = 0; i < 3; i++) wr(DW'(16'h0a00 + i));
    rst();
    wr(16'h1234);
    rd();

    // randomized traffic, alternating fill-biased and drain-biased phases
    for (int i = 0; i < 600; i++) begin
      int  pw, pr;
      logic w, r, f, rs;
      pw = ((i / 50) % 2 == 0) ? 80 : 35;
      pr = ((i / 50) % 2 == 0) ? 35 : 80;
      w  = ($urandom_range(0, 99) < pw);
      r  = ($urandom_range(0, 99) < pr);
      f  = ($urandom_range(0, 99) < 2);
      rs = (i == 317);
      cycle(rs, w, r, f, DW'($urandom_range(0, 16'hffff)));
    end
    rst();
    idle();

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
